// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded control and operands for the EX stage,
// with squash (flush), freeze (hold) and a saturating count of bubbles entering EX.
module id_ex_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              hold,
   input  logic              in_valid,
   input  logic              RegW,
   input  logic              branch,
   input  logic              MemRW,
   input  logic [1:0]        MemReg,
   input  logic [3:0]        alu_op,
   input  logic [DATA_W-1:0] pc,
   input  logic [DATA_W-1:0] rs1_data,
   input  logic [DATA_W-1:0] rs2_data,
   input  logic [DATA_W-1:0] imm,
   input  logic [REG_W-1:0]  rs1,
   input  logic [REG_W-1:0]  rs2,
   input  logic [REG_W-1:0]  rd,
   output logic              RegW_ex,
   output logic              branch_ex,
   output logic              MemRW_ex,
   output logic [1:0]        MemReg_ex,
   output logic [3:0]        alu_op_ex,
   output logic [DATA_W-1:0] pc_ex,
   output logic [DATA_W-1:0] rs1_data_ex,
   output logic [DATA_W-1:0] rs2_data_ex,
   output logic [DATA_W-1:0] imm_ex,
   output logic [REG_W-1:0]  rs1_ex,
   output logic [REG_W-1:0]  rs2_ex,
   output logic [REG_W-1:0]  rd_ex,
   output logic              valid_ex,
   output logic [CNT_W-1:0]  bubble_cnt
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   logic              r_vld_p1;
   logic              r_regw_p1;
   logic              r_branch_p1;
   logic              r_memrw_p1;
   logic [1:0]        r_memreg_p1;
   logic [3:0]        r_alu_op_p1;
   logic [DATA_W-1:0] r_pc_p1;
   logic [DATA_W-1:0] r_rs1_data_p1;
   logic [DATA_W-1:0] r_rs2_data_p1;
   logic [DATA_W-1:0] r_imm_p1;
   logic [REG_W-1:0]  r_rs1_p1;
   logic [REG_W-1:0]  r_rs2_p1;
   logic [REG_W-1:0]  r_rd_p1;
   logic [CNT_W-1:0]  r_bubble_cnt;

   // ID -> EX boundary; hold falls through with no assignment so every flop keeps its value
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_vld_p1      <= 1'b0;
         r_regw_p1     <= 1'b0;
         r_branch_p1   <= 1'b0;
         r_memrw_p1    <= 1'b0;
         r_memreg_p1   <= '0;
         r_alu_op_p1   <= '0;
         r_pc_p1       <= '0;
         r_rs1_data_p1 <= '0;
         r_rs2_data_p1 <= '0;
         r_imm_p1      <= '0;
         r_rs1_p1      <= '0;
         r_rs2_p1      <= '0;
         r_rd_p1       <= '0;
         r_bubble_cnt  <= rst ? '0 : sat_inc(r_bubble_cnt);
      end else if (!hold) begin
         r_vld_p1      <= in_valid;
         r_regw_p1     <= in_valid & RegW;
         r_branch_p1   <= in_valid & branch;
         r_memrw_p1    <= in_valid & MemRW;
         r_memreg_p1   <= in_valid ? MemReg : 2'b00;
         r_alu_op_p1   <= in_valid ? alu_op : 4'b0000;
         r_pc_p1       <= pc;
         r_rs1_data_p1 <= rs1_data;
         r_rs2_data_p1 <= rs2_data;
         r_imm_p1      <= imm;
         r_rs1_p1      <= rs1;
         r_rs2_p1      <= rs2;
         r_rd_p1       <= rd;
         if (!in_valid) begin
            r_bubble_cnt <= sat_inc(r_bubble_cnt);
         end
      end
   end

   assign valid_ex    = r_vld_p1;
   assign RegW_ex     = r_regw_p1;
   assign branch_ex   = r_branch_p1;
   assign MemRW_ex    = r_memrw_p1;
   assign MemReg_ex   = r_memreg_p1;
   assign alu_op_ex   = r_alu_op_p1;
   assign pc_ex       = r_pc_p1;
   assign rs1_data_ex = r_rs1_data_p1;
   assign rs2_data_ex = r_rs2_data_p1;
   assign imm_ex      = r_imm_p1;
   assign rs1_ex      = r_rs1_p1;
   assign rs2_ex      = r_rs2_p1;
   assign rd_ex       = r_rd_p1;
   assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: the driver queues the hand-computed EX state expected after
// each edge; the monitor pops one entry per edge and compares it with the registered outputs.
module tb_id_ex_reg;

   localparam int VW = 169;

   logic        clk = 1'b0;
   logic        rst, flush, hold, in_valid, RegW, branch, MemRW;
   logic [1:0]  MemReg;
   logic [3:0]  alu_op;
   logic [31:0] pc, rs1_data, rs2_data, imm;
   logic [4:0]  rs1, rs2, rd;
   logic        RegW_ex, branch_ex, MemRW_ex, valid_ex;
   logic [1:0]  MemReg_ex;
   logic [3:0]  alu_op_ex;
   logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
   logic [4:0]  rs1_ex, rs2_ex, rd_ex;
   logic [15:0] bubble_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   logic          q_chk[$];
   logic [VW-1:0] q_exp[$];
   string         q_name[$];

   always #5 clk = ~clk;

   id_ex_reg dut (
      .clk(clk), .rst(rst), .flush(flush), .hold(hold), .in_valid(in_valid),
      .RegW(RegW), .branch(branch), .MemRW(MemRW), .MemReg(MemReg), .alu_op(alu_op),
      .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
      .rs1(rs1), .rs2(rs2), .rd(rd),
      .RegW_ex(RegW_ex), .branch_ex(branch_ex), .MemRW_ex(MemRW_ex), .MemReg_ex(MemReg_ex),
      .alu_op_ex(alu_op_ex), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
      .imm_ex(imm_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
      .valid_ex(valid_ex), .bubble_cnt(bubble_cnt)
   );

   function automatic logic [VW-1:0] mk(input logic v, rw, br, mw, input logic [1:0] mr,
                                        input logic [3:0] al, input logic [31:0] p, d1, d2, im,
                                        input logic [4:0] s1, s2, d, input logic [15:0] cnt);
      return {v, rw, br, mw, mr, al, p, d1, d2, im, s1, s2, d, cnt};
   endfunction

   task automatic drive(input logic r, f, h, iv, rw, br, mw, input logic [1:0] mr,
                        input logic [3:0] al, input logic [31:0] p, d1, d2, im,
                        input logic [4:0] s1, s2, d);
      @(negedge clk);
      rst = r; flush = f; hold = h; in_valid = iv;
      RegW = rw; branch = br; MemRW = mw; MemReg = mr; alu_op = al;
      pc = p; rs1_data = d1; rs2_data = d2; imm = im; rs1 = s1; rs2 = s2; rd = d;
   endtask

   task automatic expect_out(input logic c, input logic [VW-1:0] e, input string n);
      q_chk.push_back(c);
      q_exp.push_back(e);
      q_name.push_back(n);
   endtask

   // Monitor: one scoreboard entry per rising edge, sampled 1 time unit after the edge
   initial begin
      logic [VW-1:0] act, e;
      logic          c;
      string         n;
      forever begin
         @(posedge clk);
         #1;
         if (q_exp.size() > 0) begin
            c = q_chk.pop_front();
            e = q_exp.pop_front();
            n = q_name.pop_front();
            act = {valid_ex, RegW_ex, branch_ex, MemRW_ex, MemReg_ex, alu_op_ex, pc_ex,
                   rs1_data_ex, rs2_data_ex, imm_ex, rs1_ex, rs2_ex, rd_ex, bubble_cnt};
            if (c) begin
               n_cmp++;
               if (act !== e) begin
                  n_bad++;
                  $display("FAIL %s: got %h required %h", n, act, e);
               end
            end
         end
      end
   end

   initial begin
      logic [VW-1:0] e_load;
      logic [15:0]   ecnt;
      int            t;
      rst = 1'b1; flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
      RegW = 1'b0; branch = 1'b0; MemRW = 1'b0; MemReg = '0; alu_op = '0;
      pc = '0; rs1_data = '0; rs2_data = '0; imm = '0; rs1 = '0; rs2 = '0; rd = '0;

      // reset overrides flush, hold and a valid instruction
      drive(1, 1, 1, 1, 1, 1, 1, 2'b11, 4'hF, 32'h1234, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3);
      expect_out(1, '0, "reset");

      drive(0, 0, 0, 1, 1, 0, 0, 2'b01, 4'b0010, 32'h40, 32'h1111_1111, 32'h2222_2222, 32'h8, 5'd1, 5'd2, 5'd7);
      e_load = mk(1, 1, 0, 0, 2'b01, 4'b0010, 32'h40, 32'h1111_1111, 32'h2222_2222, 32'h8, 5'd1, 5'd2, 5'd7, 16'd0);
      expect_out(1, e_load, "load");

      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 0, 1, 0, 0, 2'b01, 4'b0010, 32'h44, 32'h3333_3333, 32'h4444_4444, 32'hC, 5'd3, 5'd4, 5'd9);
         expect_out(1, e_load, "hold");
      end

      drive(0, 0, 0, 0, 1, 0, 0, 2'b01, 4'b0010, 32'h44, 32'h3333_3333, 32'h4444_4444, 32'hC, 5'd3, 5'd4, 5'd9);
      expect_out(1, mk(0, 0, 0, 0, 2'b00, 4'h0, 32'h44, 32'h3333_3333, 32'h4444_4444, 32'hC, 5'd3, 5'd4, 5'd9, 16'd1), "hold_release");

      drive(0, 0, 0, 1, 1, 1, 1, 2'b10, 4'b0101, 32'h48, 32'h5555_5555, 32'h6666_6666, 32'h10, 5'd5, 5'd6, 5'd10);
      expect_out(1, mk(1, 1, 1, 1, 2'b10, 4'b0101, 32'h48, 32'h5555_5555, 32'h6666_6666, 32'h10, 5'd5, 5'd6, 5'd10, 16'd1), "load_all_ctrl");

      drive(0, 1, 1, 1, 1, 0, 1, 2'b01, 4'b0011, 32'h4C, 32'h7777_7777, 32'h8888_8888, 32'h14, 5'd7, 5'd8, 5'd11);
      expect_out(1, mk(0, 0, 0, 0, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'd2), "flush_over_hold");

      drive(0, 0, 0, 0, 1, 1, 1, 2'b11, 4'hF, 32'h80, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFF0, 5'd3, 5'd4, 5'd31);
      expect_out(1, mk(0, 0, 0, 0, 2'b00, 4'h0, 32'h80, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'hFFFF_FFF0, 5'd3, 5'd4, 5'd31, 16'd3), "gating");

      drive(0, 0, 0, 1, 0, 1, 0, 2'b00, 4'b1000, 32'hC0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h4, 5'd12, 5'd13, 5'd14);
      expect_out(1, mk(1, 0, 1, 0, 2'b00, 4'b1000, 32'hC0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h4, 5'd12, 5'd13, 5'd14, 16'd3), "load_branch");

      drive(0, 1, 0, 0, 1, 1, 1, 2'b11, 4'hF, 32'hC4, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3);
      expect_out(1, mk(0, 0, 0, 0, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'd4), "flush");

      drive(0, 0, 0, 1, 1, 0, 0, 2'b01, 4'h1, 32'hC8, 32'h9, 32'hA, 32'hB, 5'd15, 5'd16, 5'd17);
      expect_out(1, mk(1, 1, 0, 0, 2'b01, 4'h1, 32'hC8, 32'h9, 32'hA, 32'hB, 5'd15, 5'd16, 5'd17, 16'd4), "load_after_flush");

      drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 32'hCC, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      expect_out(1, mk(0, 0, 0, 0, 2'b00, 4'h0, 32'hCC, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'd5), "bubble");

      drive(0, 0, 0, 1, 1, 0, 1, 2'b10, 4'h6, 32'hD0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h20, 5'd18, 5'd19, 5'd20);
      expect_out(1, mk(1, 1, 0, 1, 2'b10, 4'h6, 32'hD0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h20, 5'd18, 5'd19, 5'd20, 16'd5), "load_cnt5");

      drive(1, 0, 1, 1, 1, 1, 1, 2'b11, 4'hF, 32'hD4, 32'h1, 32'h1, 32'h1, 5'd1, 5'd1, 5'd1);
      expect_out(1, '0, "rst_midop");

      drive(0, 0, 0, 1, 1, 0, 0, 2'b01, 4'h2, 32'hD8, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3);
      expect_out(1, mk(1, 1, 0, 0, 2'b01, 4'h2, 32'hD8, 32'h11, 32'h22, 32'h33, 5'd1, 5'd2, 5'd3, 16'd0), "post_rst_load");

      // saturation: reset, then 65537 bubble edges alternating flush and invalid loads
      drive(1, 0, 0, 0, 0, 0, 0, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
      expect_out(1, '0, "sat_reset");
      for (int k = 1; k <= 65537; k++) begin
         if (k % 2 == 1)
            drive(0, 1, 0, 1, 1, 0, 1, 2'b01, 4'h3, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
         else
            drive(0, 0, 0, 0, 1, 1, 1, 2'b11, 4'hF, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
         ecnt = (k < 65535) ? 16'(k) : 16'hFFFF;
         expect_out((k <= 2) || (k >= 65534), mk(0, 0, 0, 0, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, ecnt),
                    $sformatf("sat_k%0d", k));
      end

      drive(0, 0, 1, 0, 1, 1, 1, 2'b11, 4'hF, 32'hE0, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3);
      expect_out(1, mk(0, 0, 0, 0, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 16'hFFFF), "sat_hold_invalid");

      drive(0, 0, 0, 1, 0, 0, 1, 2'b00, 4'h9, 32'hE4, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3);
      expect_out(1, mk(1, 0, 0, 1, 2'b00, 4'h9, 32'hE4, 32'h5, 32'h6, 32'h7, 5'd1, 5'd2, 5'd3, 16'hFFFF), "sat_load");

      t = 0;
      while (q_exp.size() > 0 && t < 10) begin
         @(posedge clk);
         t++;
      end
      #2;
      if (q_exp.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d entries left, required 0", q_exp.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
